// File: rtl/frame_bitmap_store.sv
// Multi-channel per-frame hit bitmap: accumulates indices from N_CH producers and commits
// the bitmap, its popcount and an out-of-range flag on every vsync rising edge.
module frame_bitmap_store #(
  parameter int unsigned WIDTH = 480,
  parameter int unsigned IDX_W = 16,
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vsync,
  input  logic [N_CH-1:0]            data_valid,
  input  logic [N_CH*IDX_W-1:0]      data,
  input  logic                       accumulate,
  input  logic                       clear,
  output logic [WIDTH-1:0]           bitmap_out,
  output logic [$clog2(WIDTH+1)-1:0] hit_count,
  output logic                       out_of_range,
  output logic                       finished,
  output logic [CNT_W-1:0]           frame_count
);

  localparam int unsigned HcW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] OneHot = WIDTH'(1);

  logic             vsync_prev;
  logic             vsync_edge;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] set_term;
  logic [WIDTH-1:0] merged;
  logic             oor_sticky;
  logic             oor_cur;
  logic [HcW-1:0]   pop;

  assign vsync_edge = vsync & ~vsync_prev;
  assign merged     = work | set_term;

  // Duplicate indices across channels OR into the same bit, so they count once.
  always_comb begin
    set_term = '0;
    oor_cur  = 1'b0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (data_valid[k]) begin
        if (32'(data[k*IDX_W +: IDX_W]) < WIDTH) begin
          set_term = set_term | (OneHot << data[k*IDX_W +: IDX_W]);
        end else begin
          oor_cur = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int b = 0; b < int'(WIDTH); b++) begin
      pop = pop + HcW'(merged[b]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_prev   <= 1'b1;
      work         <= '0;
      oor_sticky   <= 1'b0;
      bitmap_out   <= '0;
      hit_count    <= '0;
      out_of_range <= 1'b0;
      finished     <= 1'b0;
      frame_count  <= '0;
    end else begin
      vsync_prev <= vsync;
      finished   <= 1'b0;
      if (vsync_edge) begin
        // Writes landing in the edge cycle belong to the frame being committed.
        bitmap_out   <= merged;
        hit_count    <= pop;
        out_of_range <= oor_sticky | oor_cur;
        finished     <= 1'b1;
        frame_count  <= frame_count + CNT_W'(1);
        work         <= (clear || !accumulate) ? '0 : merged;
        oor_sticky   <= 1'b0;
      end else if (clear) begin
        work       <= '0;
        oor_sticky <= 1'b0;
      end else begin
        work       <= merged;
        oor_sticky <= oor_sticky | oor_cur;
      end
    end
  end

endmodule

// File: tb/tb_frame_bitmap_store.sv
// Directed bench for frame_bitmap_store: expected commits are queued when vsync rises and
// checked when the finished pulse appears.
module tb_frame_bitmap_store;

  localparam int unsigned WIDTH = 480;
  localparam int unsigned IDX_W = 16;
  localparam int unsigned N_CH  = 2;
  localparam int unsigned CNT_W = 2;

  typedef struct {
    logic [WIDTH-1:0] bm;
    logic [8:0]       hc;
    logic             oor;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  vsync;
  logic [N_CH-1:0]       data_valid;
  logic [N_CH*IDX_W-1:0] data;
  logic                  accumulate;
  logic                  clear;
  logic [WIDTH-1:0]      bitmap_out;
  logic [8:0]            hit_count;
  logic                  out_of_range;
  logic                  finished;
  logic [CNT_W-1:0]      frame_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] fc_model = '0;
  logic prev_fin = 1'b0;

  frame_bitmap_store #(
    .WIDTH(WIDTH),
    .IDX_W(IDX_W),
    .N_CH (N_CH),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .vsync       (vsync),
    .data_valid  (data_valid),
    .data        (data),
    .accumulate  (accumulate),
    .clear       (clear),
    .bitmap_out  (bitmap_out),
    .hit_count   (hit_count),
    .out_of_range(out_of_range),
    .finished    (finished),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] bm_of(input int a, input int b);
    logic [WIDTH-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    return v;
  endfunction

  // One clock: drive inputs, then return 1 time unit after the rising edge.
  task automatic cyc(input logic v0, input int i0, input logic v1, input int i1,
                     input logic vs, input logic clr);
    data_valid = {v1, v0};
    data       = {16'(i1), 16'(i0)};
    vsync      = vs;
    clear      = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  // Queue the expected commit, raise vsync (optionally writing ch0 in the edge cycle), drop it.
  task automatic commit(input logic [WIDTH-1:0] bm, input int hc, input logic oor,
                        input logic v0, input int i0);
    exp_t e;
    fc_model = fc_model + 1'b1;
    e.bm  = bm;
    e.hc  = 9'(hc);
    e.oor = oor;
    e.fc  = fc_model;
    sb.push_back(e);
    cyc(v0, i0, 1'b0, 0, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (finished) begin
      checks++;
      assert (!prev_fin) else begin
        errors++;
        $error("FAIL finished_width: observed 2-cycle pulse expected 1-cycle");
      end
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_commit: observed finished expected none (fc=%0d)", frame_count);
      end
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (bitmap_out === e.bm) else begin
          errors++;
          $error("FAIL bitmap_out: observed %0h expected %0h", bitmap_out, e.bm);
        end
        checks++;
        assert (hit_count === e.hc) else begin
          errors++;
          $error("FAIL hit_count: observed %0d expected %0d", hit_count, e.hc);
        end
        checks++;
        assert (out_of_range === e.oor) else begin
          errors++;
          $error("FAIL out_of_range: observed %0b expected %0b", out_of_range, e.oor);
        end
        checks++;
        assert (frame_count === e.fc) else begin
          errors++;
          $error("FAIL frame_count: observed %0d expected %0d", frame_count, e.fc);
        end
      end
    end
    prev_fin <= finished;
  end

  initial begin
    reset      = 1'b1;
    accumulate = 1'b0;
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
    reset = 1'b0;
    // vsync high straight out of reset must not commit.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 0, 1'b0, 0, 1'b1, 1'b0);
      chk("reset_bitmap", bitmap_out, '0);
      chk("reset_hits", WIDTH'(hit_count), '0);
      chk("reset_oor", WIDTH'(out_of_range), '0);
      chk("reset_fc", WIDTH'(frame_count), '0);
      chk("reset_fin", WIDTH'(finished), '0);
    end
    idle(1);

    // Per-frame mode, both ends of the range in one cycle.
    cyc(1'b1, 5, 1'b1, 479, 1'b0, 1'b0);
    commit(bm_of(5, 479), 2, 1'b0, 1'b0, 0);
    cyc(1'b1, 3, 1'b0, 0, 1'b0, 1'b0);
    chk("hold_bitmap", bitmap_out, bm_of(5, 479));
    chk("hold_hits", WIDTH'(hit_count), WIDTH'(2));
    commit(bm_of(3, -1), 1, 1'b0, 1'b0, 0);
    commit('0, 0, 1'b0, 1'b0, 0);

    // Out-of-range index alongside index 0; flag clears on the next empty frame.
    cyc(1'b1, 480, 1'b1, 0, 1'b0, 1'b0);
    commit(bm_of(0, -1), 1, 1'b1, 1'b0, 0);
    commit('0, 0, 1'b0, 1'b0, 0);

    // Write in the edge cycle lands in that commit, not the next.
    idle(1);
    commit(bm_of(100, -1), 1, 1'b0, 1'b1, 100);
    commit('0, 0, 1'b0, 1'b0, 0);

    // Accumulate mode, then clear colliding with a write.
    accumulate = 1'b1;
    cyc(1'b1, 10, 1'b0, 0, 1'b0, 1'b0);
    commit(bm_of(10, -1), 1, 1'b0, 1'b0, 0);
    cyc(1'b0, 0, 1'b1, 20, 1'b0, 1'b0);
    commit(bm_of(10, 20), 2, 1'b0, 1'b0, 0);
    cyc(1'b1, 30, 1'b0, 0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b1, 40, 1'b0, 1'b0);
    commit(bm_of(40, -1), 1, 1'b0, 1'b0, 0);
    // Out-of-range stays per frame while bits persist.
    cyc(1'b0, 0, 1'b1, 999, 1'b0, 1'b0);
    commit(bm_of(40, -1), 1, 1'b1, 1'b0, 0);
    accumulate = 1'b0;
    commit(bm_of(40, -1), 1, 1'b0, 1'b0, 0);

    // Duplicate index across channels counts once.
    cyc(1'b1, 7, 1'b1, 7, 1'b0, 1'b0);
    commit(bm_of(7, -1), 1, 1'b0, 1'b0, 0);

    // Reset mid-frame discards pending hits and counters.
    cyc(1'b1, 50, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    reset = 1'b0;
    chk("midreset_bitmap", bitmap_out, '0);
    chk("midreset_fc", WIDTH'(frame_count), '0);
    fc_model = '0;
    idle(1);
    commit('0, 0, 1'b0, 1'b0, 0);

    idle(3);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL missing_commit: observed %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_bitmap_store.md
Name: frame_bitmap_store

Overview:
- Multi-channel, parametrised successor to the single-index vsync storage block.
- Runs on the system pixel clock and accumulates per-frame line/column hit indices from N_CH producers into a WIDTH-bit working bitmap.
- On each vsync rising edge it commits the bitmap, its population count and error flags to stable outputs and pulses `finished` for the VGA renderer.
- Supports a per-frame clear mode and a persistent accumulate mode.

Parameters:
- WIDTH, 480, number of bitmap bits (valid indices 0..WIDTH-1).
- IDX_W, 16, width of each channel index.
- N_CH, 2, number of independent index channels.
- CNT_W, 16, frame counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- vsync  in  1  frame sync level, synchronous to clk; rising edge ends a frame.
- data_valid  in  N_CH  per-channel index strobe.
- data  in  N_CH*IDX_W  packed indices; channel k occupies bits [k*IDX_W +: IDX_W].
- accumulate  in  1  0 = working bitmap cleared at each commit; 1 = bits persist across frames.
- clear  in  1  synchronous wipe of the working bitmap.
- bitmap_out  out  WIDTH  committed bitmap of the last completed frame.
- hit_count  out  $clog2(WIDTH+1)  popcount of bitmap_out.
- out_of_range  out  1  last committed frame saw at least one valid index >= WIDTH.
- finished  out  1  one-cycle pulse on commit.
- frame_count  out  CNT_W  number of commits since reset; wraps.

Behaviour:
- Reset: every output is 0. Working bitmap and oor_sticky are cleared. vsync_d is set to 1, so no commit occurs until vsync is seen low and then high.
- Edge detect: edge = vsync & ~vsync_d. vsync_d <= vsync every cycle.
- Per-cycle set term S: for each k with data_valid[k]=1 and data_k < WIDTH, S[data_k] = 1. Indices duplicated across channels set the bit once. Indices >= WIDTH set nothing and set oor_cur.
- Non-edge cycle, clear=0: work <= work | S; oor_sticky <= oor_sticky | oor_cur.
- Non-edge cycle, clear=1: work <= 0 and oor_sticky <= 0. That cycle's writes are dropped. Outputs are unchanged.
- Edge cycle (commit):
  - bitmap_out <= work | S.
  - hit_count <= popcount(work | S).
  - out_of_range <= oor_sticky | oor_cur.
  - finished <= 1.
  - frame_count <= frame_count + 1, wrapping at 2^CNT_W.
  - Writes in the edge cycle belong to the frame being committed.
- Post-commit working state:
  - clear=1 or accumulate=0: work <= 0.
  - Otherwise: work <= work | S.
  - oor_sticky <= 0 in all cases; the flag is per frame even in accumulate mode.
- finished is high for exactly one cycle per edge, and is 0 on every non-edge cycle.
- Commit latency: outputs update on the clock after the vsync rise is sampled. vsync must be held high for at least one clk cycle.
- accumulate is sampled only on the edge cycle.
- bitmap_out, hit_count and out_of_range hold stable between commits.
- Reset mid-frame discards all pending hits with no commit. Reset has priority over edge, clear and writes.
- popcount is combinational over WIDTH bits. It is registered only at commit, giving one register stage.

Test Plan:
- Reset with vsync=1 throughout, then hold 3 cycles -> all outputs 0, no finished pulse.
- Per-frame mode: ch0 writes 5, ch1 writes 479, same cycle; vsync 0->1 -> bitmap_out bits 5 and 479 set, hit_count=2, finished single pulse, frame_count=1; next frame with no writes commits hit_count=0.
- Boundaries: ch0 writes 480, ch1 writes 0 -> bit 0 only, out_of_range=1, hit_count=1; next empty frame -> out_of_range=0.
- Edge-cycle write: ch0 writes 100 in the exact vsync-rise cycle -> bit 100 appears in that commit, not the next one.
- accumulate=1: frame 1 writes 10, frame 2 writes 20 -> second commit hit_count=2. Assert clear mid-frame 3 in the same cycle as a write of 30, then write 40 -> third commit shows only bit 40.
- Duplicates and wrap: both channels write 7 in the same cycle -> hit_count=1. With CNT_W=2, five edges -> frame_count=1.
